// File: rtl/wb_bus_master.sv
// wb_bus_master: initiator side of the on-chip IO bus, one transaction at a time.
// Optional statistics counters are enabled with `define WB_MASTER_STATS_EN.
module wb_bus_master #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TO_W    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_busy,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic [31:0] cpu_rdata,
   output logic [31:0] io_bus_addr,
   output logic [31:0] io_bus_dat2,
   input  logic [31:0] io_bus_dat4,
   output logic        io_bus_sel,
   output logic        io_bus_we,
   input  logic        io_bus_ack
`ifdef WB_MASTER_STATS_EN
   ,
   output logic [15:0] stat_txn,
   output logic [7:0]  stat_err
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      RDLAT,
      DONE
   } state_t;

   // Last counter value before a missing ack turns into an error completion.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   // Reject timeouts outside 1..65535 or too wide for the counter.
   generate
      if (TIMEOUT < 1 || TIMEOUT > 65535 ||
          ((TIMEOUT - 1) >> TO_W) != 0) begin : g_bad_timeout
         $error("wb_bus_master: TIMEOUT does not fit TO_W or is out of range");
      end
   endgenerate

   state_t          state;
   logic [TO_W-1:0] cnt;

   // Transaction FSM; every bus and CPU output is a register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         io_bus_sel  <= 1'b0;
         io_bus_we   <= 1'b0;
         io_bus_addr <= '0;
         io_bus_dat2 <= '0;
         cpu_busy    <= 1'b0;
         cpu_done    <= 1'b0;
         cpu_err     <= 1'b0;
         cpu_rdata   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               cpu_done  <= 1'b0;
               io_bus_we <= 1'b0;
               if (cpu_req) begin
                  state       <= ACTIVE;
                  cnt         <= '0;
                  io_bus_sel  <= 1'b1;
                  io_bus_we   <= cpu_we;
                  io_bus_addr <= cpu_addr;
                  io_bus_dat2 <= cpu_wdata;
                  cpu_busy    <= 1'b1;
                  cpu_err     <= 1'b0;
               end
            end
            ACTIVE: begin
               // Ack wins over a timeout that expires in the same cycle.
               if (io_bus_ack) begin
                  io_bus_sel <= 1'b0;
                  if (io_bus_we) begin
                     state    <= DONE;
                     cpu_done <= 1'b1;
                  end else begin
                     state <= RDLAT;
                  end
               end else if (cnt == TO_LAST) begin
                  state      <= DONE;
                  io_bus_sel <= 1'b0;
                  cpu_done   <= 1'b1;
                  cpu_err    <= 1'b1;
                  cpu_rdata  <= '0;
               end else begin
                  cnt <= cnt + TO_W'(1);
               end
            end
            RDLAT: begin
               // Slave registers its read data, so it is valid one cycle after ack.
               state     <= DONE;
               cpu_rdata <= io_bus_dat4;
               cpu_done  <= 1'b1;
            end
            DONE: begin
               state     <= IDLE;
               cpu_done  <= 1'b0;
               cpu_busy  <= 1'b0;
               io_bus_we <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef WB_MASTER_STATS_EN
   // Saturating completion and error counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_txn <= '0;
         stat_err <= '0;
      end else if (cpu_done) begin
         if (stat_txn != '1) begin
            stat_txn <= stat_txn + 16'd1;
         end
         if (cpu_err && stat_err != '1) begin
            stat_err <= stat_err + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_wb_bus_master.sv
// tb_wb_bus_master: randomized scoreboard bench for wb_bus_master.
// Slave model acks after a per-transaction delay and returns registered read data.
module tb_wb_bus_master;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_busy;
   logic        cpu_done;
   logic        cpu_err;
   logic [31:0] cpu_rdata;
   logic [31:0] io_bus_addr;
   logic [31:0] io_bus_dat2;
   logic [31:0] io_bus_dat4 = '0;
   logic        io_bus_sel;
   logic        io_bus_we;
   logic        io_bus_ack = 1'b0;
`ifdef WB_MASTER_STATS_EN
   logic [15:0] stat_txn;
   logic [7:0]  stat_err;
`endif

   wb_bus_master #(
      .TIMEOUT(T),
      .TO_W(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cpu_req(cpu_req),
      .cpu_we(cpu_we),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_busy(cpu_busy),
      .cpu_done(cpu_done),
      .cpu_err(cpu_err),
      .cpu_rdata(cpu_rdata),
      .io_bus_addr(io_bus_addr),
      .io_bus_dat2(io_bus_dat2),
      .io_bus_dat4(io_bus_dat4),
      .io_bus_sel(io_bus_sel),
      .io_bus_we(io_bus_we),
      .io_bus_ack(io_bus_ack)
`ifdef WB_MASTER_STATS_EN
      ,
      .stat_txn(stat_txn),
      .stat_err(stat_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          selc;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   int m_txn = 0;
   int m_err = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, expv);
   endtask

   // Edge counter used to measure completion latency.
   always @(posedge clk) cyc <= cyc + 1;

   // Slave: ack on sel cycle cur_d+1, read data appears one cycle later.
   int          sc = 0;
   bit          pend = 0;
   int          cur_d = 0;
   logic [31:0] cur_rd = '0;

   always @(negedge clk) begin
      if (reset) begin
         io_bus_ack = 1'b0;
         io_bus_dat4 = $urandom;
         sc = 0;
         pend = 0;
      end else begin
         if (pend) io_bus_dat4 = cur_rd;
         else io_bus_dat4 = $urandom;
         pend = 0;
         if (io_bus_sel) begin
            if (sc == cur_d) begin
               io_bus_ack = 1'b1;
               io_bus_dat4 = ~cur_rd;
               pend = 1;
            end else begin
               io_bus_ack = 1'b0;
            end
            sc++;
         end else begin
            sc = 0;
            io_bus_ack = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: compares each completion against the scoreboard head.
   exp_t cur;
   bit   have = 0;
   bit   busy_prev = 0;
   int   acc_t = 0;
   int   selc = 0;

   always @(negedge clk) begin
      if (reset) begin
         have = 0;
         busy_prev = 0;
         m_txn = 0;
         m_err = 0;
      end else begin
         if (cpu_busy && !busy_prev) begin
            acc_t = cyc;
            selc = 0;
            chk("accept_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               cur = exp_q[0];
               have = 1;
            end
         end
         if (cpu_busy && have) begin
            chk("hold_addr", io_bus_addr, cur.addr);
            chk("hold_dat2", io_bus_dat2, cur.wdata);
            chk("hold_we", 32'(io_bus_we), 32'(cur.we));
         end
         if (!cpu_busy) begin
            chk("idle_sel", 32'(io_bus_sel), 32'd0);
            chk("idle_we", 32'(io_bus_we), 32'd0);
         end
         if (io_bus_sel) selc++;
         if (cpu_done) begin
            chk("done_expected", 32'(have), 32'd1);
            if (have) begin
               void'(exp_q.pop_front());
               chk("err", 32'(cpu_err), 32'(cur.err));
               chk("latency", 32'(cyc - acc_t + 1), 32'(cur.lat));
               chk("sel_cycles", 32'(selc), 32'(cur.selc));
               if (!cur.we || cur.err) chk("rdata", cpu_rdata, cur.rdata);
               if (m_txn < 65535) m_txn++;
               if (cur.err && m_err < 255) m_err++;
               have = 0;
            end
         end
         busy_prev = cpu_busy;
      end
   end

   // Wait (bounded) for the master to go idle, driving junk requests meanwhile.
   task automatic wait_idle();
      int k = 0;
      while (cpu_busy && k < 64) begin
         cpu_req = 1'($urandom_range(0, 1));
         cpu_we = 1'($urandom_range(0, 1));
         cpu_addr = $urandom;
         cpu_wdata = $urandom;
         @(negedge clk);
         k++;
      end
      chk("idle_wait", 32'(cpu_busy), 32'd0);
   endtask

   task automatic issue(input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int d);
      exp_t e;
      wait_idle();
      cpu_req = 1'b1;
      cpu_we = w;
      cpu_addr = a;
      cpu_wdata = wd;
      cur_d = d;
      cur_rd = rd;
      e.we = w;
      e.addr = a;
      e.wdata = wd;
      e.err = (d >= T);
      e.rdata = e.err ? 32'd0 : rd;
      e.selc = e.err ? T : d + 1;
      e.lat = e.err ? T + 1 : d + (w ? 2 : 3);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic drain();
      wait_idle();
      cpu_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic reset_mid_read();
      issue(1'b0, 32'h0000_0058, 32'd0, 32'h1357_9BDF, 100);
      repeat (2) @(negedge clk);
      cpu_req = 1'b0;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      chk("rst_abort_sel", 32'(io_bus_sel), 32'd0);
      chk("rst_abort_busy", 32'(cpu_busy), 32'd0);
      chk("rst_abort_rdata", cpu_rdata, 32'd0);
      chk("rst_abort_done", 32'(cpu_done), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_sel", 32'(io_bus_sel), 32'd0);
      chk("rst_we", 32'(io_bus_we), 32'd0);
      chk("rst_addr", io_bus_addr, 32'd0);
      chk("rst_dat2", io_bus_dat2, 32'd0);
      chk("rst_busy", 32'(cpu_busy), 32'd0);
      chk("rst_done", 32'(cpu_done), 32'd0);
      chk("rst_err", 32'(cpu_err), 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      issue(1'b1, 32'h0000_0040, 32'h0000_00A5, 32'd0, 0);
      issue(1'b0, 32'h0000_0044, 32'd0, 32'h0000_005A, 0);
      issue(1'b0, 32'h0000_0048, 32'd0, 32'h0000_1234, 4);
      issue(1'b1, 32'h0000_004C, 32'h0000_0077, 32'd0, 4);
      issue(1'b0, 32'h0000_0050, 32'd0, 32'hDEAD_BEEF, 100);
      issue(1'b1, 32'h0000_0054, 32'h0000_0099, 32'd0, 0);
      issue(1'b0, 32'h0000_0056, 32'd0, 32'h0BAD_F00D, T - 1);
      issue(1'b1, 32'h0000_005C, 32'h0000_0011, 32'd0, 100);
      reset_mid_read();
      issue(1'b0, 32'h0000_0060, 32'd0, 32'h0000_CAFE, 1);

      for (int i = 0; i < 150; i++) begin
         int d;
         d = $urandom_range(0, 9);
         issue(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, d);
      end
      drain();

`ifdef WB_MASTER_STATS_EN
      chk("stat_txn", 32'(stat_txn), 32'(m_txn));
      chk("stat_err", 32'(stat_err), 32'(m_err));
      force dut.stat_txn = 16'hFFFF;
      @(negedge clk);
      release dut.stat_txn;
      m_txn = 65535;
      issue(1'b1, 32'h0000_0070, 32'h0000_0001, 32'd0, 0);
      drain();
      chk("stat_txn_sat", 32'(stat_txn), 32'h0000_FFFF);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
